// File: rtl/cache_pkg.sv
// Shared definitions for the L2 tag lookup slice: default geometry, lookup FSM
// states and the registered response record.
package cache_pkg;

  localparam int unsigned TAG_W_DEF   = 5;
  localparam int unsigned INDEX_W_DEF = 4;
  localparam int unsigned WAYS_DEF    = 4;

  // Response fields are sized for the largest supported geometry (8 ways, 32-bit tag).
  localparam int unsigned MAX_WAY_W = 3;
  localparam int unsigned MAX_TAG_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    RESP
  } lookupState_e;

  typedef struct packed {
    logic                 hit;
    logic [MAX_WAY_W-1:0] way;
    logic                 evict;
    logic [MAX_TAG_W-1:0] evictTag;
  } lookupResp_t;

endpackage

// File: rtl/lru_age_update.sv
// Combinational age-based LRU step for one set: applies a touch to the given way
// and reports which way currently holds the oldest age.
module lru_age_update #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][WAY_W-1:0] ageIn,
  input  logic [WAY_W-1:0]           touchWay,
  output logic [WAYS-1:0][WAY_W-1:0] ageOut,
  output logic [WAY_W-1:0]           lruWay
);

  always_comb begin
    ageOut = ageIn;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == touchWay) begin
        ageOut[w] = '0;
      end else if (ageIn[w] < ageIn[touchWay]) begin
        ageOut[w] = ageIn[w] + WAY_W'(1);
      end
    end
  end

  // Ages form a permutation, so exactly one way is oldest; scan high-to-low anyway
  // so the lowest index wins should that ever be violated.
  always_comb begin
    lruWay = '0;
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (ageIn[w-1] == WAY_W'(WAYS - 1)) begin
        lruWay = WAY_W'(w - 1);
      end
    end
  end

endmodule

// File: rtl/tag_lookup_unit.sv
// Set-associative tag store with a three-state lookup controller: hit/way lookup,
// LRU victim fill on allocating misses, and evicted-tag reporting.
module tag_lookup_unit
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W   = TAG_W_DEF,
  parameter int unsigned INDEX_W = INDEX_W_DEF,
  parameter int unsigned WAYS    = WAYS_DEF,
  localparam int unsigned WAY_W  = $clog2(WAYS),
  localparam int unsigned SETS   = 2 ** INDEX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TAG_W+INDEX_W-1:0] req_addr,
  input  logic                     req_alloc,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_hit,
  output logic [WAY_W-1:0]         resp_way,
  output logic                     resp_evict,
  output logic [TAG_W-1:0]         resp_evict_tag
);

  lookupState_e                         state;
  logic [SETS-1:0][WAYS-1:0]            validQ;
  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] ageQ;
  logic [TAG_W-1:0]                     tagMem [SETS][WAYS];

  logic [TAG_W-1:0]   reqTag;
  logic [INDEX_W-1:0] reqIndex;
  logic               reqAlloc;
  lookupResp_t        respQ;
  logic               respValidQ;

  logic [WAYS-1:0]            setValid;
  logic [WAYS-1:0][WAY_W-1:0] setAge;
  logic [WAYS-1:0][WAY_W-1:0] newAge;
  logic [WAYS-1:0]            match;
  logic                       hit;
  logic                       anyInvalid;
  logic [WAY_W-1:0]           hitWay;
  logic [WAY_W-1:0]           freeWay;
  logic [WAY_W-1:0]           lruWay;
  logic [WAY_W-1:0]           victim;
  logic [WAY_W-1:0]           touchWay;
  logic                       evictNow;
  lookupResp_t                respNext;

  assign setValid = validQ[reqIndex];
  assign setAge   = ageQ[reqIndex];

  always_comb begin
    match      = '0;
    hit        = 1'b0;
    anyInvalid = 1'b0;
    hitWay     = '0;
    freeWay    = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      match[w] = setValid[w] && (tagMem[reqIndex][w] == reqTag);
    end
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (match[w-1]) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w - 1);
      end
      if (!setValid[w-1]) begin
        anyInvalid = 1'b1;
        freeWay    = WAY_W'(w - 1);
      end
    end
  end

  assign victim   = anyInvalid ? freeWay : lruWay;
  assign touchWay = hit ? hitWay : victim;
  assign evictNow = !hit && reqAlloc && setValid[victim];

  lru_age_update #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) uLru (
    .ageIn    (setAge),
    .touchWay (touchWay),
    .ageOut   (newAge),
    .lruWay   (lruWay)
  );

  always_comb begin
    respNext          = '0;
    respNext.hit      = hit;
    respNext.way      = MAX_WAY_W'(touchWay);
    respNext.evict    = evictNow;
    respNext.evictTag = evictNow ? MAX_TAG_W'(tagMem[reqIndex][victim]) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      validQ     <= '0;
      reqTag     <= '0;
      reqIndex   <= '0;
      reqAlloc   <= 1'b0;
      respQ      <= '0;
      respValidQ <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          ageQ[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            validQ <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
              for (int unsigned w = 0; w < WAYS; w++) begin
                ageQ[s][w] <= WAY_W'(w);
              end
            end
          end else if (req_valid) begin
            reqTag   <= req_addr[TAG_W+INDEX_W-1:INDEX_W];
            reqIndex <= req_addr[INDEX_W-1:0];
            reqAlloc <= req_alloc;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          // State commits here, before the response is visible, so a following
          // request to the same set observes this fill and LRU update.
          if (hit || reqAlloc) begin
            ageQ[reqIndex] <= newAge;
            if (!hit) begin
              validQ[reqIndex][victim] <= 1'b1;
            end
          end
          respQ      <= respNext;
          respValidQ <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            respValidQ <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag contents carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (state == COMPARE && !hit && reqAlloc) begin
      tagMem[reqIndex][victim] <= reqTag;
    end
  end

  assign req_ready      = (state == IDLE) && !flush;
  assign resp_valid     = respValidQ;
  assign resp_hit       = respQ.hit;
  assign resp_way       = WAY_W'(respQ.way);
  assign resp_evict     = respQ.evict;
  assign resp_evict_tag = TAG_W'(respQ.evictTag);

endmodule
